conv_frame_packer: RTL
======================

# conv_frame_packer

Transmit-side counterpart of the decoder's frame slicer. Accepts a serial information-bit stream, convolutionally encodes it (K=3, rate 1/2 or 1/3), terminates each block with two tail bits, and packs the coded symbols MSB-first into 16-bit data frames in exactly the layout the decoder's slicer consumes. Sits between the bit source (PS/testbench) and the channel/frame buffer; produces the `i_data_frame` stream the receive chain expects.

## Interface
- No parameters. Generators fixed: g0=7 (111), g1=5 (101), g2=3 (011), octal.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `en_e` input 1: enable; 0 freezes all state; outputs hold.
- `i_code_rate` input 1: 0 = rate 1/2 (`CODE_RATE_2`), 1 = rate 1/3 (`CODE_RATE_3`); sampled only on the first accepted bit of a block.
- `i_valid` input 1: `i_bit` valid.
- `i_bit` input 1: information bit.
- `i_last` input 1: qualifies `i_bit` as the final bit of the block.
- `i_ready` output 1: bit accepted when `i_valid & i_ready`.
- `o_frame` output 16: packed coded frame.
- `o_valid` output 1: `o_frame` valid; held until `o_ready`.
- `o_ready` input 1: downstream accepts frame when `o_valid & o_ready`.
- `o_last` output 1: frame is the final (padded) frame of the block.

## Operation
- Encoder state s1 (previous bit), s2 (bit before); reset to 00 at reset and at block end.
- Per symbol, with input b: c0=b^s1^s2, c1=b^s2, c2=b^s1; then s2<=s1, s1<=b.
- Rate 1/2 symbol = {c0,c1}; 8 symbols per frame.
- Rate 1/3 symbol = {c0,c1,c2}; 5 symbols per frame, `o_frame[0]`=0.
- Packing MSB-first: first symbol's c0 at bit 15, following bits descending.
- FSM: IDLE -> RUN on first accepted bit (latch rate). RUN -> TAIL on accepted bit with `i_last`. TAIL feeds two b=0 symbols, one per cycle, then -> FLUSH if the frame is partial, else -> IDLE. FLUSH loads the zero-padded partial frame with `o_last`=1, -> IDLE.
- A tail symbol that completes a frame exactly sets `o_last` on that frame; no empty frame follows.
- Single output register: a completed frame loads `o_frame` only if `!o_valid | o_ready`; otherwise the completing symbol stalls (`i_ready`=0 in IDLE/RUN; TAIL/FLUSH do not advance).
- `i_ready` = `en_e` & state in {IDLE,RUN} & !(symbol would complete frame & `o_valid` & !`o_ready`).
- Packing shift register and symbol counter clear after each completed frame.

## Timing
- Reset: `o_frame`=0, `o_valid`=0, `o_last`=0, `i_ready`=0 during reset, FSM=IDLE, s1=s2=0, counter=0.
- Latency: `o_valid` rises the cycle after the edge accepting the frame-completing symbol.
- Back-to-back: with `o_ready`=1, a frame can load on the same edge the previous one is consumed; no bubble at rate 1/2 with continuous input.
- TAIL symbols: 2 cycles; FLUSH: 1 cycle; next block accepted at IDLE the following cycle.
- `en_e`=0: no acceptance, no FSM/counter change; `o_valid`/`o_frame` held; handshake resumes unchanged.
- `i_code_rate` changes mid-block are ignored.
- Reset mid-block: partial frame and encoder state discarded, no output.

## Test plan
- Rate 1/2, bits 1,0,1,1 (`i_last` on 4th), `o_ready`=1 -> one frame 16'hE170, `o_last`=1 (symbols 11,10,00,01 + tail 01,11).
- Rate 1/3, single bit 1 with `i_last` -> one frame 16'hF700, `o_last`=1 (111,101,110).
- Rate 1/2, 6 zero bits + `i_last` on 6th -> frame 16'h0000 with `o_last`=1 (tail completes frame exactly); no further frame.
- Rate 1/2, 16 continuous bits with `o_ready`=0 -> first frame valid and held, `i_ready` drops on the 16th bit, resumes the cycle `o_ready` goes 1; second frame correct.
- `en_e` low for 3 cycles mid-block, then `rst` pulse mid-block -> output identical to unpaused run; after reset, all outputs 0 and next block encodes from state 00.

Source files
------------

// File: rtl/conv_frame_packer.sv
// rtl/conv_frame_packer.sv - K=3 convolutional encoder (rate 1/2 or 1/3) packing coded symbols into 16-bit frames
// Blocks are tail-terminated with two zero bits; the final frame is zero-padded and flagged with o_last.
module conv_frame_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_e,
  input  logic        i_code_rate,
  input  logic        i_valid,
  input  logic        i_bit,
  input  logic        i_last,
  output logic        i_ready,
  output logic [15:0] o_frame,
  output logic        o_valid,
  input  logic        o_ready,
  output logic        o_last
);

  typedef enum logic [1:0] {IDLE, RUN, TAIL, FLUSH} state_t;

  state_t      state_q, state_d;
  logic        rate_q, rate_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic [15:0] shreg_q, shreg_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        tail_q, tail_d;
  logic [15:0] frame_q, frame_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;

  logic        rate_eff;
  logic        b, c0, c1, c2;
  logic [2:0]  last_idx;
  logic        frame_done;
  logic        out_free;
  logic        in_phase;
  logic        sym_fire;
  logic [4:0]  shamt;
  logic [15:0] sym_bits;
  logic [15:0] packed_bits;

  // The rate is only latched on the first bit, so in IDLE the live input decides.
  assign rate_eff   = (state_q == IDLE) ? i_code_rate : rate_q;
  assign b          = (state_q == TAIL) ? 1'b0 : i_bit;
  assign c0         = b ^ s1_q ^ s2_q;
  assign c1         = b ^ s2_q;
  assign c2         = b ^ s1_q;
  assign last_idx   = rate_eff ? 3'd4 : 3'd7;
  assign frame_done = (cnt_q == last_idx);
  assign out_free   = !valid_q || o_ready;
  assign in_phase   = (state_q == IDLE) || (state_q == RUN);
  assign i_ready    = rst && en_e && in_phase && !(frame_done && !out_free);

  // Symbols are written directly at their MSB-first slot, so the shift register is always left-aligned.
  assign shamt       = rate_eff ? ({2'b00, cnt_q} + {1'b0, cnt_q, 1'b0}) : {1'b0, cnt_q, 1'b0};
  assign sym_bits    = rate_eff ? ({c0, c1, c2, 13'b0} >> shamt) : ({c0, c1, 14'b0} >> shamt);
  assign packed_bits = shreg_q | sym_bits;

  always_comb begin
    sym_fire = 1'b0;
    if (in_phase) begin
      sym_fire = i_valid && i_ready;
    end else if (state_q == TAIL) begin
      sym_fire = en_e && (!frame_done || out_free);
    end
  end

  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    tail_d  = tail_q;
    frame_d = frame_q;
    valid_d = valid_q;
    last_d  = last_q;

    if (en_e && valid_q && o_ready) begin
      valid_d = 1'b0;
    end

    if (sym_fire) begin
      s2_d = s1_q;
      s1_d = b;
      if (frame_done) begin
        shreg_d = 16'h0000;
        cnt_d   = 3'd0;
        frame_d = packed_bits;
        valid_d = 1'b1;
        last_d  = (state_q == TAIL) && tail_q;
      end else begin
        shreg_d = packed_bits;
        cnt_d   = cnt_q + 3'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (sym_fire) begin
          rate_d  = i_code_rate;
          tail_d  = 1'b0;
          state_d = i_last ? TAIL : RUN;
        end
      end
      RUN: begin
        if (sym_fire && i_last) begin
          tail_d  = 1'b0;
          state_d = TAIL;
        end
      end
      TAIL: begin
        if (sym_fire) begin
          if (tail_q) begin
            s1_d    = 1'b0;
            s2_d    = 1'b0;
            state_d = frame_done ? IDLE : FLUSH;
          end else begin
            tail_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (en_e && out_free) begin
          frame_d = shreg_q;
          valid_d = 1'b1;
          last_d  = 1'b1;
          shreg_d = 16'h0000;
          cnt_d   = 3'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rate_q  <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      shreg_q <= 16'h0000;
      cnt_q   <= 3'd0;
      tail_q  <= 1'b0;
      frame_q <= 16'h0000;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign o_frame = frame_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;

endmodule
